// File: rtl/pipelined_rca_if.sv
// Handshake bus for the pipelined ripple-carry adder/subtractor.
// The master drives operands and out_ready; the slave (the adder) drives
// in_ready and the result.
interface pipelined_rca_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             c_out;
  logic             ovf;

  modport master (
    output in_valid, a, b, c_in, sub, out_ready,
    input  in_ready, out_valid, s, c_out, ovf
  );

  modport slave (
    input  in_valid, a, b, c_in, sub, out_ready,
    output in_ready, out_valid, s, c_out, ovf
  );
endinterface

// File: rtl/pipelined_rca.sv
// Pipelined ripple-carry adder/subtractor. The operand is cut into STAGES
// equal segments; each stage ripples one segment and registers its carry,
// the finished lower segments and the untouched upper operand bits.
// A single global advance enable gives full backpressure: every stage moves
// together or holds together.
module pipelined_rca #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  pipelined_rca_if.slave bus
);

  localparam int SEG = (STAGES >= 1 && STAGES <= WIDTH) ? WIDTH / STAGES : 1;
  localparam int MSB = WIDTH - 1;
  localparam int LST = STAGES - 1;

  generate
    if (WIDTH < 1 || STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_param_check
      $error("pipelined_rca: WIDTH must be a positive multiple of STAGES");
    end
  endgenerate

  // One segment of the ripple: SEG-bit sum with carry in the top bit.
  function automatic logic [SEG:0] seg_add(input logic [SEG-1:0] x,
                                           input logic [SEG-1:0] y,
                                           input logic           ci);
    return {1'b0, x} + {1'b0, y} + {{SEG{1'b0}}, ci};
  endfunction

  // Two's-complement overflow: like-signed operands, result of other sign.
  function automatic logic signed_ovf(input logic a_msb,
                                      input logic b_msb,
                                      input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

  logic [WIDTH-1:0] sum_q   [STAGES];
  logic [WIDTH-1:0] sum_d   [STAGES];
  logic [WIDTH-1:0] opa_q   [STAGES];
  logic [WIDTH-1:0] opa_d   [STAGES];
  logic [WIDTH-1:0] opb_q   [STAGES];
  logic [WIDTH-1:0] opb_d   [STAGES];
  logic             carry_q [STAGES];
  logic             carry_d [STAGES];
  logic             vld_q   [STAGES];
  logic             vld_d   [STAGES];
  logic             ovf_q;
  logic             ovf_d;
  logic             adv;

  // The whole pipe advances whenever the output slot is empty or draining.
  assign adv          = !vld_q[LST] || bus.out_ready;
  assign bus.in_ready = adv;
  assign bus.out_valid = vld_q[LST];
  assign bus.s         = sum_q[LST];
  assign bus.c_out     = carry_q[LST];
  assign bus.ovf       = ovf_q;

  // Next-state of every stage: stage 0 takes the port operands, stage k
  // ripples segment k using the carry registered by stage k-1.
  always_comb begin : stage_comb
    logic [SEG:0]     r;
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;

    b_eff   = bus.sub ? ~bus.b : bus.b;
    cin_eff = bus.sub ? 1'b1 : bus.c_in;

    r                  = seg_add(bus.a[SEG-1:0], b_eff[SEG-1:0], cin_eff);
    sum_d[0]           = '0;
    sum_d[0][SEG-1:0]  = r[SEG-1:0];
    carry_d[0]         = r[SEG];
    opa_d[0]           = bus.a;
    opb_d[0]           = b_eff;
    vld_d[0]           = bus.in_valid;

    for (int k = 1; k < STAGES; k++) begin
      r = seg_add(opa_q[k-1][k*SEG +: SEG], opb_q[k-1][k*SEG +: SEG], carry_q[k-1]);
      sum_d[k]               = sum_q[k-1];
      sum_d[k][k*SEG +: SEG] = r[SEG-1:0];
      carry_d[k]             = r[SEG];
      opa_d[k]               = opa_q[k-1];
      opb_d[k]               = opb_q[k-1];
      vld_d[k]               = vld_q[k-1];
    end

    ovf_d = signed_ovf(opa_d[LST][MSB], opb_d[LST][MSB], sum_d[LST][MSB]);
  end

  // Stage registers: cleared by reset so no in-flight beat survives it,
  // otherwise loaded together on every advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        vld_q[k]   <= 1'b0;
        sum_q[k]   <= '0;
        opa_q[k]   <= '0;
        opb_q[k]   <= '0;
        carry_q[k] <= 1'b0;
      end
      ovf_q <= 1'b0;
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        vld_q[k]   <= vld_d[k];
        sum_q[k]   <= sum_d[k];
        opa_q[k]   <= opa_d[k];
        opb_q[k]   <= opb_d[k];
        carry_q[k] <= carry_d[k];
      end
      ovf_q <= ovf_d;
    end
  end

endmodule

// File: tb/tb_pipelined_rca.sv
// Bench for pipelined_rca: directed vector table, random streams with and
// without backpressure, mid-stream reset, and a small parameter sweep.
module tb_pipelined_rca;

  localparam int W  = 32;
  localparam int ST = 4;
  localparam int NS = 30;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipelined_rca_if #(.WIDTH(32)) bus32 ();
  pipelined_rca_if #(.WIDTH(8))  bus81 ();
  pipelined_rca_if #(.WIDTH(8))  bus88 ();
  pipelined_rca_if #(.WIDTH(64)) bus642 ();
  pipelined_rca_if #(.WIDTH(33)) bus333 ();

  pipelined_rca #(.WIDTH(32), .STAGES(4)) dut     (.clk(clk), .rst_n(rst_n), .bus(bus32));
  pipelined_rca #(.WIDTH(8),  .STAGES(1)) dut_81  (.clk(clk), .rst_n(rst_n), .bus(bus81));
  pipelined_rca #(.WIDTH(8),  .STAGES(8)) dut_88  (.clk(clk), .rst_n(rst_n), .bus(bus88));
  pipelined_rca #(.WIDTH(64), .STAGES(2)) dut_642 (.clk(clk), .rst_n(rst_n), .bus(bus642));
  pipelined_rca #(.WIDTH(33), .STAGES(3)) dut_333 (.clk(clk), .rst_n(rst_n), .bus(bus333));

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        ci;
    logic        sub;
    logic [31:0] s;
    logic        c;
    logic        o;
  } vec_t;

  vec_t        vt [12];
  int          tests = 0;
  int          fails = 0;
  logic [65:0] exp_q [$];
  int          cyc_q [$];
  logic [63:0] sa [NS];
  logic [63:0] sb [NS];
  logic        sci [NS];
  logic        ssub [NS];

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Bit-serial reference: returns {ovf, c_out, s} for a w-bit operation.
  function automatic logic [65:0] model(input int w, input logic [63:0] a, input logic [63:0] b,
                                        input logic ci, input logic sub);
    logic        c;
    logic        bb;
    logic [63:0] s;
    logic        o;
    c = sub ? 1'b1 : ci;
    s = '0;
    for (int i = 0; i < w; i++) begin
      bb   = b[i] ^ sub;
      s[i] = a[i] ^ bb ^ c;
      c    = (a[i] & bb) | (c & (a[i] ^ bb));
    end
    o = (a[w-1] == (b[w-1] ^ sub)) && (s[w-1] != a[w-1]);
    return {o, c, s};
  endfunction

  task automatic run_random(input int n_beats, input int p_in, input int p_rdy,
                            input bit exact, input string tag);
    int          cyc;
    int          pushed;
    logic        prev_stall;
    logic [34:0] prev;
    logic [34:0] cur;
    logic [65:0] e;
    cyc        = 0;
    pushed     = 0;
    prev_stall = 1'b0;
    prev       = '0;
    while ((pushed < n_beats || exp_q.size() != 0) && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      cur = {bus32.out_valid, bus32.c_out, bus32.ovf, bus32.s};
      if (prev_stall) check({tag, "_hold"}, 128'(cur), 128'(prev));
      if (exact && exp_q.size() != 0 && cyc - cyc_q[0] >= ST)
        check({tag, "_lat"}, 128'(bus32.out_valid ? cyc - cyc_q[0] : 0), 128'(ST));
      bus32.out_ready = ($urandom_range(0, 99) < p_rdy);
      bus32.in_valid  = (pushed < n_beats) && ($urandom_range(0, 99) < p_in);
      bus32.a         = $urandom();
      bus32.b         = $urandom();
      bus32.c_in      = $urandom_range(0, 1) == 1;
      bus32.sub       = $urandom_range(0, 1) == 1;
      #1;
      check({tag, "_in_ready"}, 128'(bus32.in_ready), 128'(!bus32.out_valid || bus32.out_ready));
      if (bus32.out_valid && bus32.out_ready) begin
        if (exp_q.size() == 0) begin
          check({tag, "_extra_beat"}, 128'(1), 128'(0));
        end else begin
          e = exp_q.pop_front();
          void'(cyc_q.pop_front());
          check({tag, "_data"}, 128'({bus32.ovf, bus32.c_out, 32'h0, bus32.s}), 128'(e));
        end
      end
      if (bus32.in_valid && bus32.in_ready) begin
        exp_q.push_back(model(W, {32'h0, bus32.a}, {32'h0, bus32.b}, bus32.c_in, bus32.sub));
        cyc_q.push_back(cyc);
        pushed++;
      end
      prev_stall = bus32.out_valid && !bus32.out_ready;
      prev       = {bus32.out_valid, bus32.c_out, bus32.ovf, bus32.s};
    end
    bus32.in_valid = 1'b0;
    check({tag, "_drain"}, 128'(exp_q.size()), 128'(0));
    check({tag, "_beats"}, 128'(pushed), 128'(n_beats));
    exp_q.delete();
    cyc_q.delete();
  endtask

  task automatic chk_inst(input string nm, input int st, input int w, input int t,
                          input logic ov, input logic [63:0] s, input logic c, input logic o);
    int k;
    k = t - st;
    if (k >= 0 && k < NS) begin
      check({nm, "_valid"}, 128'(ov), 128'(1));
      check({nm, "_data"}, 128'({o, c, s}), 128'(model(w, sa[k], sb[k], sci[k], ssub[k])));
    end else begin
      check({nm, "_idle"}, 128'(ov), 128'(0));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    vt[0]  = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0};
    vt[1]  = '{32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1};
    vt[2]  = '{32'h00000003, 32'h00000005, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0};
    vt[3]  = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1};
    vt[4]  = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1};
    vt[5]  = '{32'h12345678, 32'h87654321, 1'b0, 1'b0, 32'h99999999, 1'b0, 1'b0};
    vt[6]  = '{32'h00000005, 32'h00000005, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0};
    vt[7]  = '{32'h00000000, 32'h00000001, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0};
    vt[8]  = '{32'h0000FFFF, 32'h00000001, 1'b1, 1'b0, 32'h00010001, 1'b0, 1'b0};
    vt[9]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0};
    vt[10] = '{32'h0000000A, 32'h00000003, 1'b1, 1'b1, 32'h00000007, 1'b1, 1'b0};
    vt[11] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1, 32'h80000000, 1'b0, 1'b1};

    for (int i = 0; i < NS; i++) begin
      sa[i]   = {$urandom(), $urandom()};
      sb[i]   = {$urandom(), $urandom()};
      sci[i]  = $urandom_range(0, 1) == 1;
      ssub[i] = $urandom_range(0, 1) == 1;
    end
    sa[0] = 64'hFFFFFFFF_FFFFFFFF; sb[0] = 64'h0; sci[0] = 1'b1; ssub[0] = 1'b0;

    bus32.in_valid = 1'b0; bus32.out_ready = 1'b1; bus32.a = '0; bus32.b = '0;
    bus32.c_in = 1'b0; bus32.sub = 1'b0;
    bus81.in_valid = 1'b0;  bus81.out_ready = 1'b1;  bus81.a = '0;  bus81.b = '0;  bus81.c_in = 1'b0;  bus81.sub = 1'b0;
    bus88.in_valid = 1'b0;  bus88.out_ready = 1'b1;  bus88.a = '0;  bus88.b = '0;  bus88.c_in = 1'b0;  bus88.sub = 1'b0;
    bus642.in_valid = 1'b0; bus642.out_ready = 1'b1; bus642.a = '0; bus642.b = '0; bus642.c_in = 1'b0; bus642.sub = 1'b0;
    bus333.in_valid = 1'b0; bus333.out_ready = 1'b1; bus333.a = '0; bus333.b = '0; bus333.c_in = 1'b0; bus333.sub = 1'b0;

    // Reset state
    #1;
    check("rst_out_valid", 128'(bus32.out_valid), 128'(0));
    check("rst_s", 128'(bus32.s), 128'(0));
    check("rst_c_out_ovf", 128'({bus32.c_out, bus32.ovf}), 128'(0));
    check("rst_in_ready", 128'(bus32.in_ready), 128'(1));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vectors, one at a time, with latency measurement
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      bus32.a = vt[i].a; bus32.b = vt[i].b; bus32.c_in = vt[i].ci; bus32.sub = vt[i].sub;
      bus32.in_valid = 1'b1; bus32.out_ready = 1'b1;
      #1;
      check($sformatf("vec%0d_in_ready", i), 128'(bus32.in_ready), 128'(1));
      @(negedge clk);
      bus32.in_valid = 1'b0;
      n = 1;
      while (!bus32.out_valid && n < 20) begin
        @(negedge clk);
        n++;
      end
      check($sformatf("vec%0d_latency", i), 128'(n), 128'(ST));
      check($sformatf("vec%0d_s", i), 128'(bus32.s), 128'(vt[i].s));
      check($sformatf("vec%0d_c_out", i), 128'(bus32.c_out), 128'(vt[i].c));
      check($sformatf("vec%0d_ovf", i), 128'(bus32.ovf), 128'(vt[i].o));
    end
    @(negedge clk);

    run_random(100, 100, 100, 1'b1, "b2b");
    run_random(200, 70, 50, 1'b0, "bp");

    // Mid-stream reset with the pipe full and the output stalled
    @(negedge clk);
    bus32.out_ready = 1'b0;
    for (int i = 0; i < ST; i++) begin
      bus32.in_valid = 1'b1; bus32.a = 32'h1000 + i; bus32.b = 32'h1; bus32.sub = 1'b0; bus32.c_in = 1'b0;
      @(negedge clk);
    end
    bus32.in_valid = 1'b0;
    #1;
    check("prerst_out_valid", 128'(bus32.out_valid), 128'(1));
    check("prerst_in_ready", 128'(bus32.in_ready), 128'(0));
    check("prerst_s", 128'(bus32.s), 128'(32'h1001));
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 128'(bus32.out_valid), 128'(0));
    check("midrst_s", 128'(bus32.s), 128'(0));
    check("midrst_c_out_ovf", 128'({bus32.c_out, bus32.ovf}), 128'(0));
    check("midrst_in_ready", 128'(bus32.in_ready), 128'(1));
    @(negedge clk);
    rst_n = 1'b1;
    bus32.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check($sformatf("postrst_idle%0d", i), 128'(bus32.out_valid), 128'(0));
    end

    // Parameter sweep: back-to-back beats on every configuration
    for (int t = 0; t < NS + 10; t++) begin
      @(negedge clk);
      chk_inst("w8s1",  1, 8,  t, bus81.out_valid,  64'(bus81.s),  bus81.c_out,  bus81.ovf);
      chk_inst("w8s8",  8, 8,  t, bus88.out_valid,  64'(bus88.s),  bus88.c_out,  bus88.ovf);
      chk_inst("w64s2", 2, 64, t, bus642.out_valid, bus642.s,      bus642.c_out, bus642.ovf);
      chk_inst("w33s3", 3, 33, t, bus333.out_valid, 64'(bus333.s), bus333.c_out, bus333.ovf);
      if (t < NS) begin
        bus81.a  = sa[t][7:0];  bus81.b  = sb[t][7:0];  bus81.c_in  = sci[t]; bus81.sub  = ssub[t];
        bus88.a  = sa[t][7:0];  bus88.b  = sb[t][7:0];  bus88.c_in  = sci[t]; bus88.sub  = ssub[t];
        bus642.a = sa[t];       bus642.b = sb[t];       bus642.c_in = sci[t]; bus642.sub = ssub[t];
        bus333.a = sa[t][32:0]; bus333.b = sb[t][32:0]; bus333.c_in = sci[t]; bus333.sub = ssub[t];
      end
      bus81.in_valid  = (t < NS);
      bus88.in_valid  = (t < NS);
      bus642.in_valid = (t < NS);
      bus333.in_valid = (t < NS);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipelined_rca.md
# pipelined_rca

Parametrised, pipelined ripple-carry adder/subtractor. The WIDTH-bit operand is split into STAGES equal segments; each pipeline stage ripples one segment and registers its carry, so long adders close timing at full clock rate. Operands and results move through a valid/ready handshake with full backpressure. It sits in the ALU datapath as the successor to the fixed-width combinational ripple-carry adders and adds subtract mode and signed overflow.

## Interface
- WIDTH, 32, operand/result width in bits; ≥ 1.
- STAGES, 4, number of pipeline stages; 1 ≤ STAGES ≤ WIDTH and WIDTH % STAGES == 0, otherwise elaboration fails. Segment width SEG = WIDTH/STAGES.

- clk  input  1  sole clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand beat present.
- in_ready  output  1  block accepts a beat this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- c_in  input  1  carry-in; used only when sub = 0.
- sub  input  1  0: s = a + b + c_in; 1: s = a − b (b inverted, carry-in forced to 1).
- out_valid  output  1  result beat present.
- out_ready  input  1  downstream accepts the result.
- s  output  WIDTH  sum/difference, modulo 2^WIDTH.
- c_out  output  1  carry out of bit WIDTH−1; in subtract mode 1 = no borrow (a ≥ b unsigned).
- ovf  output  1  signed two's-complement overflow.

## Operation
- Transfer in: in_valid && in_ready at a rising edge. Transfer out: out_valid && out_ready.
- Pipeline advance enable: adv = !out_valid || out_ready. in_ready = adv. All stages move together when adv = 1, and all hold when adv = 0 (global stall; no bubble collapsing).
- Input side: b_eff = sub ? ~b : b; cin_eff = sub ? 1 : c_in.
- Stage k (0..STAGES−1) adds segment k of a and b_eff with the carry from stage k−1 (stage 0 uses cin_eff). It registers that partial sum segment, its carry-out, the already-completed lower segments, the still-unprocessed upper operand segments, the MSBs of a and b_eff, and a valid bit.
- Bubble: when adv = 1 and no input transfer occurs, stage 0 valid loads 0. Data registers of invalid stages are don't-care but must not raise out_valid.
- Final stage outputs: s = concatenated segments; c_out = carry out of the top segment; ovf = (a[MSB] == b_eff[MSB]) && (s[MSB] != a[MSB]).
- STAGES = 1: a single registered WIDTH-bit ripple adder with the same handshake.
- Arithmetic is pure modulo 2^WIDTH. Carries never leak between beats.

## Timing
- Reset (rst_n low, asynchronous): all stage valid bits 0; out_valid = 0, s = 0, c_out = 0, ovf = 0. in_ready = 1 as soon as reset is asserted, because it is combinational from out_valid.
- Reset mid-operation discards every in-flight beat. No partial result is emitted after release.
- Latency: a beat accepted at edge n is presented with out_valid = 1 after edge n+STAGES−1 (visible in cycle n+STAGES) when there is no stall. Each stall cycle adds exactly one cycle.
- Throughput: 1 beat/cycle while out_ready = 1.
- Stall: out_valid && !out_ready holds s/c_out/ovf/out_valid stable and drops in_ready in the same cycle (combinational).
- Simultaneous out transfer and in transfer in one cycle is legal and loses no beat.
- Ordering: results leave in acceptance order; at most STAGES beats in flight.

## Test plan
- Reset: rst_n low mid-stream with 3 beats in flight -> out_valid = 0, s = 0, in_ready = 1 immediately; no stale beat appears after release.
- Full carry ripple (WIDTH = 32, STAGES = 4): a = 0xFFFFFFFF, b = 0, c_in = 1, sub = 0 -> after 4 cycles s = 0x00000000, c_out = 1, ovf = 0.
- Subtract / signed overflow: a = 0x80000000, b = 1, sub = 1 -> s = 0x7FFFFFFF, c_out = 1, ovf = 1. Then a = 3, b = 5, sub = 1 -> s = 0xFFFFFFFE, c_out = 0, ovf = 0.
- Back-to-back: 100 random beats with in_valid and out_ready held at 1 -> one result per cycle, matches a reference model, exact latency of 4.
- Backpressure: random out_ready (50 %) and random in_valid -> no loss, duplication or reordering; outputs stable while stalled; in_ready == (!out_valid || out_ready) every cycle.
- Parameter sweep: (WIDTH, STAGES) = (8,1), (8,8), (64,2), (33,3) -> same random checks pass; latency equals STAGES. (32,3) fails elaboration.
